// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// State/owner enums plus the starvation-counter width helper.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    // A zero limit still needs a 1-bit counter so the port widths stay legal.
    function automatic int starve_cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = surrounding pipeline/debug/memory view.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;

    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_gnt_o;
    logic              dbg_done_o;
    logic [DATA_W-1:0] dbg_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-3:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_done_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_done_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of CPU grants taken while debug waits; clear wins over inc.
// o_limit is a registered compare, so it reflects grants from earlier cycles only.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit
);

    localparam int            CW  = starve_cnt_w(LIMIT);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_limit = (r_cnt >= LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and a debug port; 3+ cycles per access.
// CPU has fixed priority; the starvation counter hands debug the port after STARVE_LIMIT CPU wins.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic w_limit;
    logic w_dbg_win;
    logic w_cpu_win;
    logic w_rd_ack;
    logic w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^{bus.cpu_addr_i[1:0], bus.dbg_addr_i[1:0]};

    // Debug takes the port when the CPU is absent or has used up its starvation budget.
    assign w_dbg_win = (r_state == IDLE) && bus.dbg_req_i && (!bus.cpu_req_i || w_limit);
    assign w_cpu_win = (r_state == IDLE) && bus.cpu_req_i && !w_dbg_win;
    assign w_rd_ack  = (r_state == BUSY) && bus.mem_ack_i && !r_we;

    dmem_arb_starve_ctr #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_inc   (w_cpu_win && bus.dbg_req_i),
        .i_clr   (w_dbg_win),
        .o_limit (w_limit)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_cpu_win || w_dbg_win) w_state_nxt = BUSY;
            BUSY:    if (bus.mem_ack_i)          w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.dbg_gnt_o   = 1'b0;
        bus.dbg_done_o  = 1'b0;
        unique case (r_state)
            IDLE: bus.dbg_gnt_o = w_dbg_win;
            BUSY: begin
                bus.mem_en_o    = 1'b1;
                bus.mem_we_o    = r_we;
                bus.mem_addr_o  = r_addr;
                bus.mem_wdata_o = r_wdata;
            end
            DONE:    bus.dbg_done_o = (r_owner == OWN_DBG);
            default: ;
        endcase
    end

    // Combinational so the pipeline freezes in the same cycle the request appears.
    assign bus.cpu_stall_o = bus.cpu_req_i && !((r_state == DONE) && (r_owner == OWN_CPU));
    assign bus.cpu_rdata_o = r_cpu_rdata;
    assign bus.dbg_rdata_o = r_dbg_rdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_dbg_win) begin
            r_owner <= OWN_DBG;
            r_we    <= bus.dbg_we_i;
            r_addr  <= bus.dbg_addr_i[ADDR_W-1:2];
            r_wdata <= bus.dbg_wdata_i;
        end else if (w_cpu_win) begin
            r_owner <= OWN_CPU;
            r_we    <= bus.cpu_we_i;
            r_addr  <= bus.cpu_addr_i[ADDR_W-1:2];
            r_wdata <= bus.cpu_wdata_i;
        end
    end

    // Only reads refresh the owner's data register; writes leave the last load visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else if (w_rd_ack) begin
            if (r_owner == OWN_CPU) begin
                r_cpu_rdata <= bus.mem_rdata_i;
            end else begin
                r_dbg_rdata <= bus.mem_rdata_i;
            end
        end
    end

endmodule
